// File: rtl/motor_cmd_pkg.sv
// Shared opcodes, response words and command-word layout for the motor command sequencer.
package motor_cmd_pkg;

  localparam int WORD_W     = 16;
  localparam int OP_W       = 3;
  localparam int ARG_W      = 13;
  localparam int SEL_W      = 4;
  localparam int STAT_ENA_W = 10;
  localparam int POSRST_BIT = 4;
  localparam int VAL_BIT    = 0;

  localparam logic [OP_W-1:0] OP_SELECT   = 3'd0;
  localparam logic [OP_W-1:0] OP_DIR      = 3'd1;
  localparam logic [OP_W-1:0] OP_DIV      = 3'd2;
  localparam logic [OP_W-1:0] OP_ENA      = 3'd3;
  localparam logic [OP_W-1:0] OP_READ_HI  = 3'd4;
  localparam logic [OP_W-1:0] OP_STATUS   = 3'd5;
  localparam logic [OP_W-1:0] OP_STOP_ALL = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD     = 3'd7;

  localparam logic [WORD_W-1:0] RESP_OK   = 16'h4F4B;
  localparam logic [WORD_W-1:0] RESP_ERR  = 16'hEEEE;
  localparam logic [WORD_W-1:0] RESP_BUSY = 16'hBB00;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GUARD = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ARG_W-1:0] arg;
  } cmd_word_t;

endpackage

// File: rtl/motor_cmd_sequencer_if.sv
// Command word in / response word out between the SSP slave and the sequencer.
interface motor_cmd_sequencer_if;
  import motor_cmd_pkg::*;

  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic [WORD_W-1:0] resp_data;
  logic              cmd_error;

  modport master (output word_valid, word_data, input resp_data, cmd_error);
  modport slave  (input word_valid, word_data, output resp_data, cmd_error);

endinterface

// File: rtl/motor_cmd_guard_timer.sv
// Direction-change guard down-counter: start loads DIR_GUARD, abort clears it.
// mid fires on the edge the count reaches DIR_GUARD/2, done on the edge it reaches zero.
module motor_cmd_guard_timer #(
  parameter int DIR_GUARD = 16
) (
  input  logic CLK,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic mid,
  output logic done
);

  localparam logic [7:0] LOAD    = 8'(DIR_GUARD);
  localparam logic [7:0] MID_PRE = 8'(DIR_GUARD / 2 + 1);

  logic [7:0] cnt;

  always_ff @(posedge CLK) begin
    if (reset || abort) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= LOAD;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  // Zero means idle, so both strobes look one count ahead of their target value.
  assign mid  = (cnt == MID_PRE);
  assign done = (cnt == 8'd1);

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Decodes SPI command words into per-motor shadow config, commits it to the live channel
// outputs (with a timed guard when reversing a running motor) and returns one response per word.
module motor_cmd_sequencer
  import motor_cmd_pkg::*;
#(
  parameter int NUM_MOTORS = 6,
  parameter int DIV_W      = 13,
  parameter int POS_W      = 32,
  parameter int DIR_GUARD  = 16
) (
  input  logic                        CLK,
  input  logic                        reset,
  motor_cmd_sequencer_if.slave        cmd,
  input  logic [NUM_MOTORS*POS_W-1:0] cur_position,
  output logic                        busy,
  output logic                        sel_valid,
  output logic [SEL_W-1:0]            sel_motor,
  output logic [NUM_MOTORS*DIV_W-1:0] divider,
  output logic [NUM_MOTORS-1:0]       move_dir,
  output logic [NUM_MOTORS-1:0]       step_ena,
  output logic [NUM_MOTORS-1:0]       pos_reset
);

  localparam int IDX_W = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
  localparam logic [SEL_W-1:0] MOTOR_LIMIT = SEL_W'(NUM_MOTORS);

  seq_state_t state_q, state_d;

  logic                                 sel_valid_q, sel_valid_d;
  logic [SEL_W-1:0]                     sel_motor_q, sel_motor_d;
  logic [NUM_MOTORS-1:0]                pos_reset_q, pos_reset_d;
  logic [POS_W-1:0]                     snap_q, snap_d;
  logic [NUM_MOTORS-1:0]                sh_dir_q, sh_dir_d;
  logic [NUM_MOTORS-1:0][DIV_W-1:0]     sh_div_q, sh_div_d;
  logic [NUM_MOTORS-1:0]                dir_q, dir_d;
  logic [NUM_MOTORS-1:0][DIV_W-1:0]     div_q, div_d;
  logic [NUM_MOTORS-1:0]                ena_q, ena_d;
  logic [WORD_W-1:0]                    resp_q, resp_d;
  logic                                 err_q, err_d;

  logic [NUM_MOTORS-1:0][POS_W-1:0]     pos_arr;
  cmd_word_t                            cmd_w;
  logic [IDX_W-1:0]                     s_idx;
  logic [IDX_W-1:0]                     m_idx;
  logic                                 needs_sel;
  logic                                 tmr_start, tmr_abort, tmr_mid, tmr_done;

  assign pos_arr   = cur_position;
  assign cmd_w     = cmd_word_t'(cmd.word_data);
  assign s_idx     = sel_motor_q[IDX_W-1:0];
  assign m_idx     = cmd_w.arg[IDX_W-1:0];
  assign needs_sel = (cmd_w.op >= OP_DIR) && (cmd_w.op <= OP_READ_HI);

  motor_cmd_guard_timer #(
    .DIR_GUARD(DIR_GUARD)
  ) u_guard (
    .CLK  (CLK),
    .reset(reset),
    .start(tmr_start),
    .abort(tmr_abort),
    .mid  (tmr_mid),
    .done (tmr_done)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sel_valid_q <= 1'b0;
      sel_motor_q <= '0;
      pos_reset_q <= '0;
      snap_q      <= '0;
      sh_dir_q    <= '0;
      sh_div_q    <= '0;
      dir_q       <= '0;
      div_q       <= '0;
      ena_q       <= '0;
      resp_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_valid_q <= sel_valid_d;
      sel_motor_q <= sel_motor_d;
      pos_reset_q <= pos_reset_d;
      snap_q      <= snap_d;
      sh_dir_q    <= sh_dir_d;
      sh_div_q    <= sh_div_d;
      dir_q       <= dir_d;
      div_q       <= div_d;
      ena_q       <= ena_d;
      resp_q      <= resp_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_valid_d = sel_valid_q;
    sel_motor_d = sel_motor_q;
    pos_reset_d = pos_reset_q;
    snap_d      = snap_q;
    sh_dir_d    = sh_dir_q;
    sh_div_d    = sh_div_q;
    dir_d       = dir_q;
    div_d       = div_q;
    ena_d       = ena_q;
    resp_d      = resp_q;
    err_d       = 1'b0;
    tmr_start   = 1'b0;
    tmr_abort   = 1'b0;

    // Guard events land first so a word on the completing edge sees IDLE semantics.
    if (state_q == ST_GUARD) begin
      if (tmr_mid) begin
        dir_d[s_idx] = sh_dir_q[s_idx];
        div_d[s_idx] = sh_div_q[s_idx];
      end
      if (tmr_done) begin
        ena_d[s_idx] = 1'b1;
        state_d      = ST_IDLE;
      end
    end

    if (cmd.word_valid) begin
      if (state_d == ST_GUARD && cmd_w.op != OP_STATUS && cmd_w.op != OP_STOP_ALL) begin
        resp_d = RESP_BUSY;
        err_d  = 1'b1;
      end else if (needs_sel && !sel_valid_q) begin
        resp_d = RESP_ERR;
        err_d  = 1'b1;
      end else begin
        case (cmd_w.op)
          OP_SELECT: begin
            if (cmd_w.arg[SEL_W-1:0] >= MOTOR_LIMIT) begin
              resp_d = RESP_ERR;
              err_d  = 1'b1;
            end else begin
              sel_motor_d        = cmd_w.arg[SEL_W-1:0];
              sel_valid_d        = 1'b1;
              pos_reset_d[m_idx] = cmd_w.arg[POSRST_BIT];
              snap_d             = pos_arr[m_idx];
              resp_d             = pos_arr[m_idx][15:0];
            end
          end
          OP_DIR: begin
            sh_dir_d[s_idx] = cmd_w.arg[VAL_BIT];
            resp_d          = RESP_OK;
          end
          OP_DIV: begin
            if (cmd_w.arg == '0) begin
              resp_d = RESP_ERR;
              err_d  = 1'b1;
            end else begin
              sh_div_d[s_idx] = DIV_W'(cmd_w.arg);
              resp_d          = RESP_OK;
            end
          end
          OP_ENA: begin
            resp_d = RESP_OK;
            if (!cmd_w.arg[VAL_BIT]) begin
              ena_d[s_idx] = 1'b0;
            end else if (!ena_d[s_idx] || sh_dir_q[s_idx] == dir_d[s_idx]) begin
              div_d[s_idx] = sh_div_q[s_idx];
              dir_d[s_idx] = sh_dir_q[s_idx];
              ena_d[s_idx] = 1'b1;
            end else begin
              // Running motor reversing: stop stepping, swap config mid-guard, restart at end.
              ena_d[s_idx] = 1'b0;
              state_d      = ST_GUARD;
              tmr_start    = 1'b1;
            end
          end
          OP_READ_HI: begin
            resp_d = snap_q[31:16];
          end
          OP_STATUS: begin
            resp_d = {sel_motor_q, (state_d == ST_GUARD), sel_valid_q, STAT_ENA_W'(ena_d)};
          end
          OP_STOP_ALL: begin
            ena_d  = '0;
            resp_d = RESP_OK;
            if (state_d == ST_GUARD) begin
              state_d   = ST_IDLE;
              tmr_abort = 1'b1;
            end
          end
          OP_RSVD: begin
            resp_d = RESP_ERR;
            err_d  = 1'b1;
          end
        endcase
      end
    end
  end

  assign cmd.resp_data = resp_q;
  assign cmd.cmd_error = err_q;
  assign busy          = (state_q == ST_GUARD);
  assign sel_valid     = sel_valid_q;
  assign sel_motor     = sel_motor_q;
  assign divider       = div_q;
  assign move_dir      = dir_q;
  assign step_ena      = ena_q;
  assign pos_reset     = pos_reset_q;

endmodule
